// File: rtl/i2s_dsp_rx_deser.sv
// DSP/TDM-mode I2S receive deserializer: assembles slot words after a frame-sync
// pulse and hands them to a 2-entry valid/ready buffer with overflow/sync flags.
module i2s_dsp_rx_deser #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic              sck_i,
   input  logic              rst_i,
   input  logic              cfg_en_i,
   input  logic [4:0]        cfg_num_bits_i,
   input  logic [2:0]        cfg_num_words_i,
   input  logic              cfg_dsp_delay_i,
   input  logic              cfg_msb_first_i,
   input  logic              ws_i,
   input  logic              sd_i,
   output logic [DATA_W-1:0] data_o,
   output logic [2:0]        slot_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              ovf_o,
   output logic              sync_err_o
);

   typedef enum logic [1:0] {StIdle, StWaitSync, StDelay, StShift} state_e;

   state_e      r_state, w_state_d;
   logic [31:0] r_shift, w_shift_d;
   logic [4:0]  r_bit_cnt, w_bit_cnt_d;
   logic [2:0]  r_slot, w_slot_d;

   logic        w_push;
   logic [31:0] w_cur;
   logic [31:0] w_first;
   logic        w_last_bit;
   logic        w_frame_end;
   logic        w_sync_err;

   logic [31:0] r_mem_data [FIFO_DEPTH];
   logic [2:0]  r_mem_slot [FIFO_DEPTH];
   logic        r_wr_ptr, r_rd_ptr;
   logic [1:0]  r_count;
   logic        r_ovf, r_sync_err;
   logic        w_full, w_pop, w_wr, w_ovf_set;

   function automatic logic [31:0] f_insert(input logic [31:0] base, input logic [4:0] pos,
                                            input logic b, input logic msb_first);
      logic [31:0] res;
      if (msb_first) begin
         res = {base[30:0], b};
      end else begin
         res      = base;
         res[pos] = b;
      end
      return res;
   endfunction

   assign w_cur       = f_insert(r_shift, r_bit_cnt, sd_i, cfg_msb_first_i);
   assign w_first     = f_insert(32'd0, 5'd0, sd_i, cfg_msb_first_i);
   assign w_last_bit  = (r_bit_cnt == cfg_num_bits_i);
   assign w_frame_end = w_last_bit && (r_slot == cfg_num_words_i);

   always_comb begin
      w_state_d   = r_state;
      w_shift_d   = r_shift;
      w_bit_cnt_d = r_bit_cnt;
      w_slot_d    = r_slot;
      w_push      = 1'b0;
      w_sync_err  = 1'b0;
      if (!cfg_en_i) begin
         w_state_d   = StIdle;
         w_shift_d   = '0;
         w_bit_cnt_d = '0;
         w_slot_d    = '0;
      end else begin
         case (r_state)
            StIdle: w_state_d = StWaitSync;
            StWaitSync: begin
               if (ws_i) begin
                  w_slot_d = '0;
                  if (cfg_dsp_delay_i) begin
                     w_state_d = StDelay;
                  end else begin
                     w_state_d   = StShift;
                     w_shift_d   = w_first;
                     w_bit_cnt_d = 5'd1;
                  end
               end
            end
            StDelay: begin
               w_state_d   = StShift;
               w_shift_d   = '0;
               w_bit_cnt_d = '0;
            end
            StShift: begin
               if (w_last_bit) begin
                  w_push      = 1'b1;
                  w_shift_d   = '0;
                  w_bit_cnt_d = '0;
                  if (r_slot == cfg_num_words_i) begin
                     w_slot_d  = '0;
                     w_state_d = StWaitSync;
                  end else begin
                     w_slot_d = r_slot + 3'd1;
                  end
               end else begin
                  w_shift_d   = w_cur;
                  w_bit_cnt_d = r_bit_cnt + 5'd1;
               end
               // A pulse on the frame's final bit is a legal back-to-back frame; any other resyncs.
               if (ws_i) begin
                  w_sync_err = !w_frame_end;
                  w_slot_d   = '0;
                  if (cfg_dsp_delay_i) begin
                     w_state_d   = StDelay;
                     w_shift_d   = '0;
                     w_bit_cnt_d = '0;
                  end else begin
                     w_state_d   = StShift;
                     w_shift_d   = w_first;
                     w_bit_cnt_d = 5'd1;
                  end
               end
            end
            default: w_state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge sck_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= StIdle;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_slot    <= '0;
      end else begin
         r_state   <= w_state_d;
         r_shift   <= w_shift_d;
         r_bit_cnt <= w_bit_cnt_d;
         r_slot    <= w_slot_d;
      end
   end

   assign w_full    = (r_count == 2'(FIFO_DEPTH));
   assign w_pop     = valid_o && ready_i;
   assign w_wr      = w_push && (!w_full || w_pop);
   assign w_ovf_set = w_push && w_full && !w_pop;

   always_ff @(posedge sck_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem_data[i] <= '0;
            r_mem_slot[i] <= '0;
         end
         r_wr_ptr   <= 1'b0;
         r_rd_ptr   <= 1'b0;
         r_count    <= '0;
         r_ovf      <= 1'b0;
         r_sync_err <= 1'b0;
      end else if (!cfg_en_i) begin
         r_wr_ptr   <= 1'b0;
         r_rd_ptr   <= 1'b0;
         r_count    <= '0;
         r_ovf      <= 1'b0;
         r_sync_err <= 1'b0;
      end else begin
         if (w_wr) begin
            r_mem_data[r_wr_ptr] <= w_cur;
            r_mem_slot[r_wr_ptr] <= r_slot;
            r_wr_ptr             <= ~r_wr_ptr;
         end
         if (w_pop) r_rd_ptr <= ~r_rd_ptr;
         r_count <= r_count + 2'(w_wr) - 2'(w_pop);
         if (w_ovf_set) r_ovf <= 1'b1;
         if (w_sync_err) r_sync_err <= 1'b1;
      end
   end

   // Head entry is masked so an empty buffer always presents zeros.
   assign valid_o    = (r_count != 2'd0);
   assign data_o     = valid_o ? DATA_W'(r_mem_data[r_rd_ptr]) : '0;
   assign slot_o     = valid_o ? r_mem_slot[r_rd_ptr] : 3'd0;
   assign ovf_o      = r_ovf;
   assign sync_err_o = r_sync_err;

endmodule

// File: tb/tb_i2s_dsp_rx_deser.sv
// Self-checking bench for i2s_dsp_rx_deser: scoreboard of expected words checked at
// each consumer handshake, plus per-scenario flag and timing checks.
module tb_i2s_dsp_rx_deser;

   logic        sck_i = 1'b0;
   logic        rst_i;
   logic        cfg_en_i;
   logic [4:0]  cfg_num_bits_i;
   logic [2:0]  cfg_num_words_i;
   logic        cfg_dsp_delay_i;
   logic        cfg_msb_first_i;
   logic        ws_i;
   logic        sd_i;
   logic [31:0] data_o;
   logic [2:0]  slot_o;
   logic        valid_o;
   logic        ready_i;
   logic        ovf_o;
   logic        sync_err_o;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [31:0] data;
      logic [2:0]  slot;
   } exp_t;

   exp_t exp_q[$];

   i2s_dsp_rx_deser #(
      .DATA_W    (32),
      .FIFO_DEPTH(2)
   ) u_dut (
      .sck_i          (sck_i),
      .rst_i          (rst_i),
      .cfg_en_i       (cfg_en_i),
      .cfg_num_bits_i (cfg_num_bits_i),
      .cfg_num_words_i(cfg_num_words_i),
      .cfg_dsp_delay_i(cfg_dsp_delay_i),
      .cfg_msb_first_i(cfg_msb_first_i),
      .ws_i           (ws_i),
      .sd_i           (sd_i),
      .data_o         (data_o),
      .slot_o         (slot_o),
      .valid_o        (valid_o),
      .ready_i        (ready_i),
      .ovf_o          (ovf_o),
      .sync_err_o     (sync_err_o)
   );

   always #5 sck_i = ~sck_i;

   // A handshake seen here is consumed at the next posedge.
   always @(negedge sck_i) begin
      exp_t e;
      if (valid_o && ready_i) begin
         checks = checks + 1;
         if (exp_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL pop_unexpected: got data=%h slot=%0d, required no word", data_o, slot_o);
         end else begin
            e = exp_q.pop_front();
            if (data_o !== e.data || slot_o !== e.slot) begin
               errors = errors + 1;
               $display("FAIL pop_word: got data=%h slot=%0d, required data=%h slot=%0d",
                        data_o, slot_o, e.data, e.slot);
            end
         end
      end
   end

   task automatic tick();
      @(posedge sck_i);
      #1;
   endtask

   task automatic send_bits(input logic [31:0] w, input int n, input bit msb);
      for (int i = 0; i < n; i++) begin
         sd_i = msb ? w[n-1-i] : w[i];
         tick();
      end
   endtask

   task automatic expect_word(input logic [31:0] d, input logic [2:0] s);
      exp_t e;
      e.data = d;
      e.slot = s;
      exp_q.push_back(e);
   endtask

   task automatic drain(input string name, input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: got %0d words outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic configure(input logic [4:0] bits, input logic [2:0] words, input logic dly,
                            input logic msb);
      cfg_en_i = 1'b0;
      ws_i     = 1'b0;
      sd_i     = 1'b0;
      tick();
      cfg_num_bits_i  = bits;
      cfg_num_words_i = words;
      cfg_dsp_delay_i = dly;
      cfg_msb_first_i = msb;
      cfg_en_i        = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (valid_o !== 1'b0 || data_o !== 32'd0 || slot_o !== 3'd0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b data=%h slot=%0d, required 0/0/0",
                  valid_o, data_o, slot_o);
      end
      checks++;
      if (ovf_o !== 1'b0 || sync_err_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: got ovf=%b sync_err=%b, required 0/0", ovf_o, sync_err_o);
      end
      tick();
      rst_i = 1'b0;
      tick();
   endtask

   task automatic test_standard_frame();
      logic [7:0] w0;
      w0 = 8'hA5;
      ready_i = 1'b1;
      configure(5'd7, 3'd1, 1'b1, 1'b1);
      expect_word(32'hA5, 3'd0);
      expect_word(32'h3C, 3'd1);
      ws_i = 1'b1;
      tick();
      ws_i = 1'b0;
      sd_i = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) begin
         sd_i = w0[7-i];
         tick();
         if (i == 6) begin
            checks++;
            if (valid_o !== 1'b0) begin
               errors++;
               $display("FAIL std_latency_early: got valid=%b 8 cycles after ws, required 0", valid_o);
            end
         end
      end
      checks++;
      if (valid_o !== 1'b1) begin
         errors++;
         $display("FAIL std_latency: got valid=%b 9 cycles after ws, required 1", valid_o);
      end
      // Next frame's pulse coincides with the last bit of slot 1.
      send_bits(32'h1E, 7, 1'b1);
      expect_word(32'h96, 3'd0);
      expect_word(32'h0F, 3'd1);
      sd_i = 1'b0;
      ws_i = 1'b1;
      tick();
      ws_i = 1'b0;
      tick();
      send_bits(32'h96, 8, 1'b1);
      send_bits(32'h0F, 8, 1'b1);
      drain("std", 10);
      checks++;
      if (sync_err_o !== 1'b0 || ovf_o !== 1'b0) begin
         errors++;
         $display("FAIL std_flags: got ovf=%b sync_err=%b, required 0/0", ovf_o, sync_err_o);
      end
   endtask

   task automatic test_lsb_first();
      logic [15:0] words [3];
      words[0] = 16'h1234;
      words[1] = 16'hBEEF;
      words[2] = 16'h0F0F;
      ready_i = 1'b1;
      configure(5'd15, 3'd0, 1'b0, 1'b0);
      for (int f = 0; f < 3; f++) begin
         expect_word({16'h0, words[f]}, 3'd0);
         ws_i = 1'b1;
         sd_i = words[f][0];
         tick();
         ws_i = 1'b0;
         send_bits({17'h0, words[f][15:1]}, 15, 1'b0);
      end
      drain("lsb", 10);
      checks++;
      if (sync_err_o !== 1'b0) begin
         errors++;
         $display("FAIL lsb_sync_err: got %b, required 0", sync_err_o);
      end
   endtask

   task automatic test_overflow();
      ready_i = 1'b0;
      configure(5'd3, 3'd3, 1'b1, 1'b1);
      expect_word(32'h1, 3'd0);
      expect_word(32'h2, 3'd1);
      ws_i = 1'b1;
      tick();
      ws_i = 1'b0;
      tick();
      send_bits(32'h1, 4, 1'b1);
      send_bits(32'h2, 4, 1'b1);
      checks++;
      if (valid_o !== 1'b1 || ovf_o !== 1'b0) begin
         errors++;
         $display("FAIL ovf_before: got valid=%b ovf=%b, required 1/0", valid_o, ovf_o);
      end
      send_bits(32'h3, 4, 1'b1);
      checks++;
      if (ovf_o !== 1'b1) begin
         errors++;
         $display("FAIL ovf_set: got ovf=%b, required 1", ovf_o);
      end
      send_bits(32'h4, 4, 1'b1);
      checks++;
      if (data_o !== 32'h1 || slot_o !== 3'd0) begin
         errors++;
         $display("FAIL ovf_head: got data=%h slot=%0d, required 1/0", data_o, slot_o);
      end
      ready_i = 1'b1;
      drain("ovf", 10);
      tick();
      checks++;
      if (valid_o !== 1'b0 || ovf_o !== 1'b1) begin
         errors++;
         $display("FAIL ovf_after: got valid=%b ovf=%b, required 0/1", valid_o, ovf_o);
      end
   endtask

   task automatic test_misplaced_sync();
      ready_i = 1'b1;
      configure(5'd7, 3'd1, 1'b1, 1'b1);
      ws_i = 1'b1;
      tick();
      ws_i = 1'b0;
      tick();
      send_bits(32'hF, 4, 1'b1);
      ws_i = 1'b1;
      sd_i = 1'b1;
      tick();
      ws_i = 1'b0;
      checks++;
      if (sync_err_o !== 1'b1 || valid_o !== 1'b0) begin
         errors++;
         $display("FAIL sync_detect: got sync_err=%b valid=%b, required 1/0", sync_err_o, valid_o);
      end
      expect_word(32'h5A, 3'd0);
      expect_word(32'hC3, 3'd1);
      sd_i = 1'b0;
      tick();
      send_bits(32'h5A, 8, 1'b1);
      send_bits(32'hC3, 8, 1'b1);
      drain("sync", 10);
      checks++;
      if (sync_err_o !== 1'b1) begin
         errors++;
         $display("FAIL sync_sticky: got %b, required 1", sync_err_o);
      end
   endtask

   task automatic test_enable_reset();
      ready_i = 1'b0;
      configure(5'd3, 3'd3, 1'b1, 1'b1);
      ws_i = 1'b1;
      tick();
      ws_i = 1'b0;
      tick();
      send_bits(32'h9, 4, 1'b1);
      send_bits(32'hA, 4, 1'b1);
      send_bits(32'hB, 4, 1'b1);
      send_bits(32'h3, 2, 1'b1);
      ws_i = 1'b1;
      tick();
      ws_i = 1'b0;
      checks++;
      if (valid_o !== 1'b1 || ovf_o !== 1'b1 || sync_err_o !== 1'b1) begin
         errors++;
         $display("FAIL en_setup: got valid=%b ovf=%b sync_err=%b, required 1/1/1",
                  valid_o, ovf_o, sync_err_o);
      end
      cfg_en_i = 1'b0;
      tick();
      checks++;
      if (valid_o !== 1'b0 || ovf_o !== 1'b0 || sync_err_o !== 1'b0) begin
         errors++;
         $display("FAIL en_clear: got valid=%b ovf=%b sync_err=%b, required 0/0/0",
                  valid_o, ovf_o, sync_err_o);
      end
      configure(5'd7, 3'd1, 1'b1, 1'b1);
      ws_i = 1'b1;
      tick();
      ws_i = 1'b0;
      tick();
      send_bits(32'h11, 8, 1'b1);
      send_bits(32'h2, 3, 1'b1);
      checks++;
      if (valid_o !== 1'b1 || data_o !== 32'h11) begin
         errors++;
         $display("FAIL rst_setup: got valid=%b data=%h, required 1/00000011", valid_o, data_o);
      end
      #2;
      rst_i = 1'b1;
      #1;
      checks++;
      if (valid_o !== 1'b0 || data_o !== 32'd0 || slot_o !== 3'd0) begin
         errors++;
         $display("FAIL rst_async: got valid=%b data=%h slot=%0d, required 0/0/0",
                  valid_o, data_o, slot_o);
      end
      tick();
      rst_i = 1'b0;
      tick();
      ready_i = 1'b1;
      expect_word(32'h22, 3'd0);
      expect_word(32'h33, 3'd1);
      ws_i = 1'b1;
      tick();
      ws_i = 1'b0;
      tick();
      send_bits(32'h22, 8, 1'b1);
      send_bits(32'h33, 8, 1'b1);
      drain("rst", 10);
      checks++;
      if (sync_err_o !== 1'b0 || ovf_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_flags: got ovf=%b sync_err=%b, required 0/0", ovf_o, sync_err_o);
      end
   endtask

   task automatic test_max_geometry();
      logic [31:0] w;
      ready_i = 1'b1;
      configure(5'd31, 3'd7, 1'b0, 1'b1);
      // Two frames of 256 cycles; the second pulse lands exactly 256 cycles after the first.
      for (int f = 0; f < 2; f++) begin
         for (int s = 0; s < 8; s++) begin
            w = $urandom;
            expect_word(w, 3'(s));
            ws_i = (s == 0);
            sd_i = w[31];
            tick();
            ws_i = 1'b0;
            send_bits(w, 31, 1'b1);
         end
      end
      drain("max", 10);
      checks++;
      if (sync_err_o !== 1'b0 || ovf_o !== 1'b0) begin
         errors++;
         $display("FAIL max_flags: got ovf=%b sync_err=%b, required 0/0", ovf_o, sync_err_o);
      end
   endtask

   initial begin
      rst_i           = 1'b1;
      cfg_en_i        = 1'b0;
      cfg_num_bits_i  = 5'd7;
      cfg_num_words_i = 3'd0;
      cfg_dsp_delay_i = 1'b1;
      cfg_msb_first_i = 1'b1;
      ws_i            = 1'b0;
      sd_i            = 1'b0;
      ready_i         = 1'b0;
      test_reset();
      test_standard_frame();
      test_lsb_first();
      test_overflow();
      test_misplaced_sync();
      test_enable_reset();
      test_max_geometry();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
